// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a multi-cycle multiply/divide sequencer.
// Define ALU_CTRL_SEQ_DIV_EN to enable the divide path.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i, ALUOp_i,       decode request (main-decoder op class,
//   funct_i                 R-type funct field)
//   flush_i                 abort an in-flight multiply/divide
//   ready_o                 request accepted when high with valid_i
//   ALUCtrl_o               registered ALU control code
//   ctrl_valid_o            pulse: ALUCtrl_o updated
//   illegal_o               pulse: undecodable request
//   mdu_op_o                01 mul, 10 div, 00 none (held while busy)
//   mdu_start_o             pulse: first busy cycle
//   hilo_we_o               pulse: last busy cycle of a completed op
//   stall_o                 high while the sequencer is busy
module alu_ctrl_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [2:0] ALUOp_i,
  input  logic [5:0] funct_i,
  input  logic       flush_i,
  output logic       ready_o,
  output logic [3:0] ALUCtrl_o,
  output logic       ctrl_valid_o,
  output logic       illegal_o,
  output logic [1:0] mdu_op_o,
  output logic       mdu_start_o,
  output logic       hilo_we_o,
  output logic       stall_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_e;

  localparam int CW = $clog2(64);

  // Counter preloads: busy spans exactly N cycles, ending at zero.
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  localparam logic [3:0] C_AND = 4'd0;
  localparam logic [3:0] C_OR  = 4'd1;
  localparam logic [3:0] C_ADD = 4'd2;
  localparam logic [3:0] C_SUB = 4'd6;
  localparam logic [3:0] C_SLT = 4'd7;
  localparam logic [3:0] C_MFH = 4'd10;
  localparam logic [3:0] C_MFL = 4'd11;
  localparam logic [3:0] C_NOR = 4'd12;
  localparam logic [3:0] C_ILL = 4'hF;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic [3:0] alu_q;
  logic [3:0] alu_d;
  logic       cv_q;
  logic       cv_d;
  logic       ill_q;
  logic       ill_d;
  logic       start_q;
  logic       start_d;

  logic [3:0] dec_code;
  logic       dec_ill;
  logic       dec_mul;
  logic       dec_div;
  logic       accept;
  logic       busy;
  logic       cnt_zero;

  // Request decode
  always_comb begin
    dec_code = C_ILL;
    dec_ill  = 1'b1;
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    unique case (1'b1)
      (ALUOp_i == 3'd0): begin
        dec_code = C_ADD;
        dec_ill  = 1'b0;
      end
      (ALUOp_i == 3'd1): begin
        dec_code = C_SUB;
        dec_ill  = 1'b0;
      end
      (ALUOp_i == 3'd3): begin
        dec_code = C_SLT;
        dec_ill  = 1'b0;
      end
      (ALUOp_i == 3'd4): begin
        dec_code = C_AND;
        dec_ill  = 1'b0;
      end
      (ALUOp_i == 3'd5): begin
        dec_code = C_OR;
        dec_ill  = 1'b0;
      end
      (ALUOp_i == 3'd2): begin
        dec_ill = 1'b0;
        case (funct_i)
          6'h20: dec_code = C_ADD;
          6'h22: dec_code = C_SUB;
          6'h24: dec_code = C_AND;
          6'h25: dec_code = C_OR;
          6'h27: dec_code = C_NOR;
          6'h2A: dec_code = C_SLT;
          6'h10: dec_code = C_MFH;
          6'h12: dec_code = C_MFL;
          // MDU ops drive add so the datapath idles.
          6'h18: begin
            dec_code = C_ADD;
            dec_mul  = 1'b1;
          end
`ifdef ALU_CTRL_SEQ_DIV_EN
          6'h1A: begin
            dec_code = C_ADD;
            dec_div  = 1'b1;
          end
`endif
          default: begin
            dec_code = C_ILL;
            dec_ill  = 1'b1;
          end
        endcase
      end
      default: begin
        dec_code = C_ILL;
        dec_ill  = 1'b1;
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign cnt_zero = (cnt_q == '0);
  assign ready_o  = !busy && !rst_i;
  assign accept   = valid_i && ready_o;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && dec_mul) begin
          state_d = S_MUL;
          cnt_d   = MUL_LOAD;
        end else if (accept && dec_div) begin
          state_d = S_DIV;
          cnt_d   = DIV_LOAD;
        end
      end
      S_MUL, S_DIV: begin
        if (flush_i || cnt_zero) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    cv_d      = accept;
    ill_d     = accept && dec_ill;
    start_d   = accept && (dec_mul || dec_div);
    alu_d     = accept ? dec_code : alu_q;
    mdu_op_o  = 2'b00;
    unique case (state_q)
      S_MUL:   mdu_op_o = 2'b01;
      S_DIV:   mdu_op_o = 2'b10;
      default: mdu_op_o = 2'b00;
    endcase
    // Flush or reset in the final cycle cancels the write.
    hilo_we_o = busy && cnt_zero && !flush_i && !rst_i;
    stall_o   = busy;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_q   <= 4'd0;
      cv_q    <= 1'b0;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      cv_q    <= cv_d;
      ill_q   <= ill_d;
      start_q <= start_d;
    end
  end

  assign ALUCtrl_o    = alu_q;
  assign ctrl_valid_o = cv_q;
  assign illegal_o    = ill_q;
  assign mdu_start_o  = start_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_alu_ctrl_seq;

  localparam int MUL_N = 4;
  localparam int DIV_N = 8;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic [2:0] ALUOp_i;
  logic [5:0] funct_i;
  logic       flush_i;
  logic       ready_o;
  logic [3:0] ALUCtrl_o;
  logic       ctrl_valid_o;
  logic       illegal_o;
  logic [1:0] mdu_op_o;
  logic       mdu_start_o;
  logic       hilo_we_o;
  logic       stall_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ALUOp_i     (ALUOp_i),
    .funct_i     (funct_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .ALUCtrl_o   (ALUCtrl_o),
    .ctrl_valid_o(ctrl_valid_o),
    .illegal_o   (illegal_o),
    .mdu_op_o    (mdu_op_o),
    .mdu_start_o (mdu_start_o),
    .hilo_we_o   (hilo_we_o),
    .stall_o     (stall_o)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h",
               name, $time, act, exp);
    end
  endtask

  // Reference decode straight from the opcode tables.
  function automatic logic [3:0] ref_code(input logic [2:0] op,
                                          input logic [5:0] f);
    case (op)
      3'd0: return 4'd2;
      3'd1: return 4'd6;
      3'd3: return 4'd7;
      3'd4: return 4'd0;
      3'd5: return 4'd1;
      3'd2: begin
        case (f)
          6'h20: return 4'd2;
          6'h22: return 4'd6;
          6'h24: return 4'd0;
          6'h25: return 4'd1;
          6'h27: return 4'd12;
          6'h2A: return 4'd7;
          6'h10: return 4'd10;
          6'h12: return 4'd11;
          6'h18: return 4'd2;
`ifdef ALU_CTRL_SEQ_DIV_EN
          6'h1A: return 4'd2;
`endif
          default: return 4'hF;
        endcase
      end
      default: return 4'hF;
    endcase
  endfunction

  // 0 single-cycle, 1 multiply, 2 divide
  function automatic int ref_kind(input logic [2:0] op,
                                  input logic [5:0] f);
    if (op == 3'd2 && f == 6'h18) return 1;
`ifdef ALU_CTRL_SEQ_DIV_EN
    if (op == 3'd2 && f == 6'h1A) return 2;
`endif
    return 0;
  endfunction

  // Model: busy cycles remaining (including the current one).
  int         m_left = 0;
  int         m_op = 0;
  logic [3:0] m_alu = 4'd0;
  bit         m_cv = 1'b0;
  bit         m_ill = 1'b0;
  bit         m_start = 1'b0;

  always @(posedge clk) begin
    if (rst_i) begin
      m_left  <= 0;
      m_op    <= 0;
      m_alu   <= 4'd0;
      m_cv    <= 1'b0;
      m_ill   <= 1'b0;
      m_start <= 1'b0;
    end else if (m_left > 0) begin
      m_cv    <= 1'b0;
      m_ill   <= 1'b0;
      m_start <= 1'b0;
      m_left  <= flush_i ? 0 : m_left - 1;
    end else begin
      m_cv    <= valid_i;
      m_ill   <= valid_i && (ref_code(ALUOp_i, funct_i) == 4'hF);
      m_start <= valid_i && (ref_kind(ALUOp_i, funct_i) != 0);
      if (valid_i) begin
        m_alu <= ref_code(ALUOp_i, funct_i);
        if (ref_kind(ALUOp_i, funct_i) == 1) begin
          m_left <= MUL_N;
          m_op   <= 1;
        end else if (ref_kind(ALUOp_i, funct_i) == 2) begin
          m_left <= DIV_N;
          m_op   <= 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", ready_o, (m_left == 0) && !rst_i);
      chk("m_stall", stall_o, m_left != 0);
      chk("m_mdu_op", mdu_op_o, (m_left != 0) ? m_op : 0);
      chk("m_hilo_we", hilo_we_o,
          (m_left == 1) && !flush_i && !rst_i);
      chk("m_alu_ctrl", ALUCtrl_o, m_alu);
      chk("m_ctrl_valid", ctrl_valid_o, m_cv);
      chk("m_illegal", illegal_o, m_ill);
      chk("m_mdu_start", mdu_start_o, m_start);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic v, input logic [2:0] op,
                       input logic [5:0] f, input logic fl,
                       input logic r);
    valid_i = v;
    ALUOp_i = op;
    funct_i = f;
    flush_i = fl;
    rst_i   = r;
    #1;
  endtask

  function automatic logic [5:0] pick_funct(input int i);
    case (i)
      0:  return 6'h20;
      1:  return 6'h22;
      2:  return 6'h24;
      3:  return 6'h25;
      4:  return 6'h27;
      5:  return 6'h2A;
      6:  return 6'h10;
      7:  return 6'h12;
      8:  return 6'h18;
      9:  return 6'h1A;
      10: return 6'h18;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    setin(0, 0, 0, 0, 1);
    step();
    step();
    setin(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_alu", ALUCtrl_o, 0);
    chk("rst_cv", ctrl_valid_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_mdu_op", mdu_op_o, 0);
    chk("rst_ready", ready_o, 1);

    // sub via funct 0x22
    setin(1, 2, 6'h22, 0, 0);
    chk("sub_ready", ready_o, 1);
    step();
    setin(0, 0, 0, 0, 0);
    chk("sub_alu", ALUCtrl_o, 6);
    chk("sub_cv", ctrl_valid_o, 1);
    chk("sub_ready1", ready_o, 1);

    // multiply, with subs queued behind it
    step();
    setin(1, 2, 6'h18, 0, 0);
    chk("mul_c0_ready", ready_o, 1);
    step();
    setin(1, 1, 0, 0, 0);
    chk("mul_c1_start", mdu_start_o, 1);
    chk("mul_c1_stall", stall_o, 1);
    chk("mul_c1_op", mdu_op_o, 1);
    chk("mul_c1_alu", ALUCtrl_o, 2);
    chk("mul_c1_cv", ctrl_valid_o, 1);
    chk("mul_c1_ready", ready_o, 0);
    step();
    chk("mul_c2_hilo", hilo_we_o, 0);
    chk("mul_c2_cv", ctrl_valid_o, 0);
    step();
    chk("mul_c3_hilo", hilo_we_o, 0);
    step();
    chk("mul_c4_hilo", hilo_we_o, 1);
    chk("mul_c4_stall", stall_o, 1);
    step();
    chk("mul_c5_ready", ready_o, 1);
    chk("mul_c5_stall", stall_o, 0);
    chk("mul_c5_hilo", hilo_we_o, 0);
    step();
    setin(0, 0, 0, 0, 0);
    chk("b2b_alu", ALUCtrl_o, 6);
    chk("b2b_cv", ctrl_valid_o, 1);

`ifdef ALU_CTRL_SEQ_DIV_EN
    step();
    setin(1, 2, 6'h1A, 0, 0);
    step();
    setin(0, 0, 0, 0, 0);
    chk("div_c1_op", mdu_op_o, 2);
    chk("div_c1_start", mdu_start_o, 1);
    step();
    step();
    setin(0, 0, 0, 1, 0);
    chk("div_c3_hilo", hilo_we_o, 0);
    chk("div_c3_stall", stall_o, 1);
    step();
    setin(0, 0, 0, 0, 0);
    chk("div_c4_stall", stall_o, 0);
    chk("div_c4_ready", ready_o, 1);
`else
    step();
    setin(1, 2, 6'h1A, 0, 0);
    step();
    setin(0, 0, 0, 0, 0);
    chk("nodiv_alu", ALUCtrl_o, 4'hF);
    chk("nodiv_ill", illegal_o, 1);
    chk("nodiv_cv", ctrl_valid_o, 1);
    chk("nodiv_stall", stall_o, 0);
`endif

    // illegal ALUOp
    step();
    setin(1, 7, 0, 0, 0);
    step();
    setin(0, 0, 0, 0, 0);
    chk("ill7_alu", ALUCtrl_o, 4'hF);
    chk("ill7_ill", illegal_o, 1);
    chk("ill7_cv", ctrl_valid_o, 1);
    step();
    chk("ill7_ill_off", illegal_o, 0);
    chk("ill7_hold", ALUCtrl_o, 4'hF);

    // reset in the middle of a multiply
    step();
    setin(1, 2, 6'h18, 0, 0);
    step();
    setin(1, 0, 0, 0, 0);
    step();
    setin(1, 0, 0, 0, 1);
    chk("rmul_hilo", hilo_we_o, 0);
    chk("rmul_ready", ready_o, 0);
    step();
    setin(1, 1, 0, 0, 0);
    chk("rmul_alu", ALUCtrl_o, 0);
    chk("rmul_cv", ctrl_valid_o, 0);
    chk("rmul_stall", stall_o, 0);
    chk("rmul_op", mdu_op_o, 0);
    chk("rmul_ready1", ready_o, 1);
    step();
    setin(0, 0, 0, 0, 0);
    chk("rmul_new_alu", ALUCtrl_o, 6);
    chk("rmul_new_cv", ctrl_valid_o, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      setin($urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)),
            pick_funct($urandom_range(0, 12)),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 99) == 0);
    end

    step();
    setin(0, 0, 0, 0, 0);
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter MUL_CYCLES, default 4, cycles a multiply occupies the sequencer (legal 1..64).
REQ-002 Parameter DIV_CYCLES, default 8, cycles a divide occupies the sequencer (legal 1..64).
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  decode request valid.
REQ-006 ALUOp_i  input  3  main-decoder ALU operation class.
REQ-007 funct_i  input  6  R-type funct field.
REQ-008 flush_i  input  1  abort any in-flight multiply/divide.
REQ-009 ready_o  output  1  request accepted this cycle when high with valid_i.
REQ-010 ALUCtrl_o  output  4  registered ALU control code.
REQ-011 ctrl_valid_o  output  1  one-cycle pulse, ALUCtrl_o updated.
REQ-012 illegal_o  output  1  one-cycle pulse with ctrl_valid_o for an undecodable request.
REQ-013 mdu_op_o  output  2  01 multiply, 10 divide, 00 none; held while busy.
REQ-014 mdu_start_o  output  1  one-cycle pulse, first busy cycle.
REQ-015 hilo_we_o  output  1  one-cycle pulse, last busy cycle of a completed multiply/divide.
REQ-016 stall_o  output  1  high whenever state is not IDLE.

Function
REQ-017 Handshake SHALL be: accept iff valid_i && ready_o; ready_o = (state==IDLE) && !rst_i; valid_i ignored when ready_o low.
REQ-018 ALUOp_i decode SHALL be: 0 add->2, 1 sub->6, 3 slt->7, 4 and->0, 5 or->1, 2 R-type via funct_i, 6/7 illegal.
REQ-019 funct_i decode (ALUOp_i=2) SHALL be: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x27 nor->12, 0x2A->7, 0x10 mfhi->10, 0x12 mflo->11, 0x18 mult, 0x1A div, all others illegal.
REQ-020 Single-cycle and mfhi/mflo requests SHALL produce ALUCtrl_o and ctrl_valid_o=1 in the cycle after acceptance, state stays IDLE (throughput one per cycle).
REQ-021 Illegal requests SHALL produce ALUCtrl_o=4'hF, ctrl_valid_o=1, illegal_o=1 in the cycle after acceptance.
REQ-022 ALUCtrl_o SHALL hold its last value while ctrl_valid_o is low.
REQ-023 States SHALL be IDLE, MUL, DIV; accepted mult -> MUL, accepted div -> DIV, counter loaded with N-1 (N = MUL_CYCLES or DIV_CYCLES).
REQ-024 Accepted mult/div SHALL assert ctrl_valid_o with ALUCtrl_o=4'd2 (add, datapath idle) in the cycle after acceptance, together with mdu_start_o.
REQ-025 In MUL/DIV the counter SHALL decrement each cycle; in the cycle counter==0, hilo_we_o=1 and next state is IDLE, so busy spans exactly N cycles.
REQ-026 flush_i high in MUL/DIV SHALL force IDLE next cycle, suppress hilo_we_o that cycle and after; flush_i in IDLE SHALL be ignored (accept still occurs).
REQ-027 flush_i and counter==0 in the same cycle SHALL flush (hilo_we_o=0).
REQ-028 Counter width SHALL be $clog2(64) = 6 bits; no wrap past zero.

Reset
REQ-029 rst_i SHALL have priority over flush_i and valid_i.
REQ-030 On reset: state IDLE, counter 0, ALUCtrl_o=4'd0, mdu_op_o=00, all pulse outputs and stall_o 0.
REQ-031 Reset during MUL/DIV SHALL abort without hilo_we_o; ready_o high the cycle after rst_i deasserts.

Configuration
REQ-032 Macro ALU_CTRL_SEQ_DIV_EN defined: divide supported per REQ-023..027.
REQ-033 Macro undefined: funct 0x1A SHALL decode as illegal (REQ-021), DIV state and DIV_CYCLES unused, mdu_op_o never 10.

Verification
REQ-034 Reset then ALUOp_i=2, funct_i=0x22, valid_i=1 one cycle -> next cycle ALUCtrl_o=6, ctrl_valid_o=1, ready_o stays 1.
REQ-035 ALUOp_i=2, funct_i=0x18, MUL_CYCLES=4, accept at cycle 0 -> mdu_start_o cycle 1, stall_o cycles 1-4, hilo_we_o cycle 4 only, ready_o high cycle 5.
REQ-036 Divide (DIV_EN on, DIV_CYCLES=8), flush_i at cycle 3 -> stall_o low cycle 4, hilo_we_o never asserted.
REQ-037 ALUOp_i=7 and separately funct_i=0x1A with DIV_EN off -> ALUCtrl_o=4'hF, illegal_o=1, ctrl_valid_o=1 one cycle.
REQ-038 rst_i at cycle 2 of a multiply with valid_i held high -> all outputs reset values, no hilo_we_o, new request accepted first cycle after rst_i low.
REQ-039 Back-to-back valid_i adds/subs during a multiply -> not accepted until ready_o returns; first accepted one decoded correctly.
